// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store with bounded fetch starvation
module mem_port_arbiter #(
  parameter int p_ADDR_W     = 10,
  parameter int p_DATA_W     = 16,
  parameter int p_MAX_STARVE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [15:0]         if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [p_DATA_W-1:0] if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [15:0]         d_addr,
  input  logic [p_DATA_W-1:0] d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [p_DATA_W-1:0] d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [p_ADDR_W-1:0] mem_addr,
  output logic [p_DATA_W-1:0] mem_wdata,
  input  logic [p_DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(p_MAX_STARVE + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic          rd_if_q, rd_if_d, rd_d_q, rd_d_d;
  logic          fetch_pri;
  // grant selection, memory drive and response routing
  always_comb begin
    fetch_pri = starve_q == SW'(p_MAX_STARVE);
    if_gnt    = ~rst & if_req & (~d_req | fetch_pri);
    d_gnt     = ~rst & d_req & ~(if_req & fetch_pri);
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = if_gnt ? if_addr[p_ADDR_W-1:0] : d_gnt ? d_addr[p_ADDR_W-1:0] : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
    starve_d  = (if_req & ~if_gnt) ? (fetch_pri ? starve_q : starve_q + 1'b1) : '0;
    rd_if_d   = if_gnt;
    rd_d_d    = d_gnt & ~d_we;
    if_rvalid = rd_if_q & ~rst;
    d_rvalid  = rd_d_q & ~rst;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end
  // starvation counter and read-return flags
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      rd_if_q  <= 1'b0;
      rd_d_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rd_if_q  <= rd_if_d;
      rd_d_q   <= rd_d_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed stimulus checked against a behavioural model
module tb_mem_port_arbiter;
  localparam int MAX = 3;
  logic        clk = 0, rst;
  logic        if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid, mem_en, mem_we;
  logic [15:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  logic [15:0] mem [1024];
  logic [15:0] ref_mem [1024];
  int total = 0, bad = 0;
  int starve = 0;
  bit pend_if = 0, pend_d = 0, seen_if = 0, seen_d = 0;
  logic [15:0] pend_if_data = 0, pend_d_data = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    bit eg_if, eg_d, ev_if, ev_d;
    logic [9:0] ea;
    eg_if = !rst && if_req && (!d_req || starve >= MAX);
    eg_d  = !rst && d_req && !eg_if;
    ea    = eg_if ? if_addr[9:0] : eg_d ? d_addr[9:0] : 10'd0;
    ev_if = pend_if && !rst;
    ev_d  = pend_d && !rst;
    chk("if_gnt", if_gnt, eg_if);
    chk("d_gnt", d_gnt, eg_d);
    chk("mem_en", mem_en, eg_if || eg_d);
    chk("mem_we", mem_we, eg_d && d_we);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, eg_d ? d_wdata : 16'd0);
    chk("if_rvalid", if_rvalid, ev_if);
    chk("if_rdata", if_rdata, ev_if ? pend_if_data : 16'd0);
    chk("d_rvalid", d_rvalid, ev_d);
    chk("d_rdata", d_rdata, ev_d ? pend_d_data : 16'd0);
    seen_if = eg_if;
    seen_d  = eg_d;
    if (rst) begin
      pend_if = 0;
      pend_d  = 0;
      starve  = 0;
    end else begin
      pend_if      = eg_if;
      pend_if_data = ref_mem[if_addr[9:0]];
      pend_d       = eg_d && !d_we;
      pend_d_data  = ref_mem[d_addr[9:0]];
      if (eg_d && d_we) ref_mem[d_addr[9:0]] = d_wdata;
      starve = (if_req && !eg_if) ? ((starve + 1 > MAX) ? MAX : starve + 1) : 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input int a, input logic [15:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) preset(i, 16'($urandom));
    rst = 1; if_req = 1; d_req = 1; d_we = 0; if_addr = 16'h0001; d_addr = 16'h0002; d_wdata = 0;
    repeat (2) step();
    rst = 0;
    step();
    d_req = 0; if_req = 0;
    step();
    preset(5, 16'hA5A5);
    if_req = 1; if_addr = 16'h0005;
    step();
    if_req = 0;
    step();
    d_req = 1; d_we = 1; d_addr = 16'h0010; d_wdata = 16'h1234;
    step();
    d_we = 0;
    step();
    d_req = 0;
    step();
    if_req = 1; d_req = 1; if_addr = 16'h0030; d_addr = 16'h0031; d_we = 0;
    repeat (12) step();
    if_req = 0;
    d_req = 1; d_we = 1; d_addr = 16'h0410; d_wdata = 16'hBEEF;
    step();
    d_req = 0; if_req = 1; if_addr = 16'h0010;
    step();
    if_req = 0;
    step();
    if_req = 1; if_addr = 16'h0020;
    step();
    if_req = 0; rst = 1;
    step();
    rst = 0;
    step();
    if_req = 1;
    step();
    if_req = 0;
    step();
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 99) == 0;
      if (!(if_req && !seen_if) || $urandom_range(0, 9) == 0) begin
        if_req  = $urandom_range(0, 2) != 0;
        if_addr = 16'($urandom_range(0, 63)) | (16'($urandom_range(0, 63)) << 10);
      end
      if (!(d_req && !seen_d) || $urandom_range(0, 9) == 0) begin
        d_req   = $urandom_range(0, 2) != 0;
        d_we    = $urandom_range(0, 1) != 0;
        d_addr  = 16'($urandom_range(0, 63)) | (16'($urandom_range(0, 63)) << 10);
        d_wdata = 16'($urandom);
      end
      step();
    end
    rst = 0; if_req = 0; d_req = 0;
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
